// File: rtl/div_seq_pkg.sv
// rtl/div_seq_pkg.sv - shared handshake levels and state encodings for the divider
package div_seq_pkg;

    localparam logic DIV_START            = 1'b1;
    localparam logic DIV_STOP             = 1'b0;
    localparam logic DIV_RESULT_READY     = 1'b1;
    localparam logic DIV_RESULT_NOT_READY = 1'b0;

    typedef enum logic [2:0] {
        DIV_FREE    = 3'b000,
        DIV_BY_ZERO = 3'b001,
        DIV_ON      = 3'b010,
        DIV_END     = 3'b011,
        DIV_OVF     = 3'b100
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring-division iteration: trial subtract and shift
module div_step #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem,
    input  logic [DATA_W-1:0] quo,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_next,
    output logic [DATA_W-1:0] quo_next
);

    logic ge;

    // Partial remainder stays below the divisor, so the shifted value fits DATA_W+2 bits.
    always_comb begin
        ge       = {rem, quo[DATA_W-1]} >= {2'b00, divisor};
        rem_next = ge ? (DATA_W+1)'({rem, quo[DATA_W-1]} - {2'b00, divisor})
                      : {rem[DATA_W-1:0], quo[DATA_W-1]};
        quo_next = {quo[DATA_W-2:0], ge};
    end

endmodule

// File: rtl/div_seq.sv
// rtl/div_seq.sv - multi-cycle radix-2 divider for RV32M DIV/DIVU/REM/REMU
module div_seq
    import div_seq_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              annul_i,
    input  logic              signed_i,
    input  logic              rem_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    output logic [DATA_W-1:0] result_o,
    output logic              ready_o,
    output logic              busy_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [DATA_W-1:0] INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    div_state_e        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W:0]   rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] divisor_q;
    logic              sgn_q, rem_sel_q, neg1_q, neg2_q, raw_q;

    logic [DATA_W:0]   rem_nx;
    logic [DATA_W-1:0] quo_nx;
    logic [DATA_W-1:0] mag1, mag2, fixed_res;

    div_step #(.DATA_W(DATA_W)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (divisor_q),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    always_comb begin
        mag1 = (signed_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
        mag2 = (signed_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;
        // Divide-by-zero and overflow results are already final and bypass the sign fix.
        if (raw_q)
            fixed_res = rem_sel_q ? rem_q[DATA_W-1:0] : quo_q;
        else if (rem_sel_q)
            fixed_res = (sgn_q && neg1_q) ? -rem_q[DATA_W-1:0] : rem_q[DATA_W-1:0];
        else
            fixed_res = (sgn_q && (neg1_q ^ neg2_q)) ? -quo_q : quo_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= DIV_FREE;
            cnt       <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            divisor_q <= '0;
            sgn_q     <= 1'b0;
            rem_sel_q <= 1'b0;
            neg1_q    <= 1'b0;
            neg2_q    <= 1'b0;
            raw_q     <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
            busy_o    <= 1'b0;
        end else if (annul_i) begin
            state   <= DIV_FREE;
            cnt     <= '0;
            ready_o <= DIV_RESULT_NOT_READY;
            busy_o  <= 1'b0;
        end else begin
            case (state)
                DIV_FREE: begin
                    if (start_i == DIV_START) begin
                        sgn_q     <= signed_i;
                        rem_sel_q <= rem_i;
                        neg1_q    <= signed_i & opdata1_i[DATA_W-1];
                        neg2_q    <= signed_i & opdata2_i[DATA_W-1];
                        divisor_q <= mag2;
                        cnt       <= '0;
                        if (opdata2_i == '0) begin
                            state <= DIV_BY_ZERO;
                            raw_q <= 1'b1;
                            quo_q <= '1;
                            rem_q <= {1'b0, opdata1_i};
                        end else if (signed_i && opdata1_i == INT_MIN && opdata2_i == '1) begin
                            state <= DIV_OVF;
                            raw_q <= 1'b1;
                            quo_q <= INT_MIN;
                            rem_q <= '0;
                        end else begin
                            state  <= DIV_ON;
                            busy_o <= 1'b1;
                            raw_q  <= 1'b0;
                            quo_q  <= mag1;
                            rem_q  <= '0;
                        end
                    end
                end
                DIV_ON: begin
                    rem_q <= rem_nx;
                    quo_q <= quo_nx;
                    cnt   <= cnt + 1'b1;
                    if (cnt == CNT_W'(DATA_W - 1)) begin
                        state  <= DIV_END;
                        busy_o <= 1'b0;
                    end
                end
                DIV_BY_ZERO, DIV_OVF: state <= DIV_END;
                DIV_END: begin
                    // First END cycle registers the result; it then holds until start drops.
                    if (ready_o && start_i == DIV_STOP) begin
                        state   <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else begin
                        ready_o  <= DIV_RESULT_READY;
                        result_o <= fixed_res;
                    end
                end
                default: state <= DIV_FREE;
            endcase
        end
    end

endmodule
